// File: rtl/ram_sdp_bypass_if.sv
// Bus between a user of the simple dual-port RAM and the RAM itself.
//   master: drives data, write_addr, we, read_addr, re; observes q, q_valid, busy
//   slave : the RAM side
interface ram_sdp_bypass_if #(
    parameter int unsigned RAM_DATA_WIDTH = 15,
    parameter int unsigned RAM_ADDR_WIDTH = 16
);
    logic [RAM_DATA_WIDTH-1:0] data;
    logic [RAM_ADDR_WIDTH-1:0] write_addr;
    logic                      we;
    logic [RAM_ADDR_WIDTH-1:0] read_addr;
    logic                      re;
    logic [RAM_DATA_WIDTH-1:0] q;
    logic                      q_valid;
    logic                      busy;

    modport master (
        output data, write_addr, we, read_addr, re,
        input  q, q_valid, busy
    );

    modport slave (
        input  data, write_addr, we, read_addr, re,
        output q, q_valid, busy
    );
endinterface

// File: rtl/ram_sdp_bypass.sv
// Simple dual-port RAM (one write port, one read port) with configurable
// read-during-write behaviour, optional output register and an optional
// post-reset sweep that fills every word with CLEAR_VALUE.
//   clk   : sole clock, rising edge
//   rst   : synchronous active-high reset
//   bus   : slave side of ram_sdp_bypass_if
//           data/write_addr/we  write port
//           read_addr/re        read request
//           q/q_valid           read result, q_valid pulses once per read
//           busy                clear sweep pending/running, requests ignored
module ram_sdp_bypass #(
    parameter int unsigned               RAM_DATA_WIDTH = 15,
    parameter int unsigned               RAM_ADDR_WIDTH = 16,
    parameter int unsigned               RDW_MODE       = 0,
    parameter int unsigned               OUT_REG        = 0,
    parameter int unsigned               CLEAR_ON_RESET = 1,
    parameter logic [RAM_DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input logic             clk,
    input logic             rst,
    ram_sdp_bypass_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** RAM_ADDR_WIDTH;

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    state_e                    state_q, state_d;
    logic [RAM_ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                      busy_q, busy_d;

    logic [RAM_DATA_WIDTH-1:0] mem [DEPTH];

    logic                      mem_we_c;
    logic [RAM_ADDR_WIDTH-1:0] mem_waddr_c;
    logic [RAM_DATA_WIDTH-1:0] mem_wdata_c;
    logic                      rd_acc_c;
    logic [RAM_DATA_WIDTH-1:0] rd_data_c;

    // s1_* is the extra stage used only when OUT_REG=1; out_* drives q/q_valid
    logic                      s1_valid_q, s1_valid_d;
    logic [RAM_DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                      out_valid_q, out_valid_d;
    logic [RAM_DATA_WIDTH-1:0] out_data_q, out_data_d;

    // Control FSM, write-port mux and read pipeline next-state
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = bus.write_addr;
        mem_wdata_c = bus.data;
        rd_acc_c    = 1'b0;

        if (!rst) begin
            unique case (state_q)
                CLEAR: begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = clr_addr_q;
                    mem_wdata_c = CLEAR_VALUE;
                    clr_addr_d  = RAM_ADDR_WIDTH'(clr_addr_q + 1'b1);
                    // terminal-count compare: leave after the last word
                    if (clr_addr_q == '1) begin
                        state_d = READY;
                    end
                end
                default: begin
                    mem_we_c = bus.we;
                    rd_acc_c = bus.re;
                end
            endcase
        end

        busy_d = (state_d == CLEAR);

        // Same-address write in the same cycle: new data is forwarded from
        // the write port, otherwise the array still holds the old word.
        rd_data_c = mem[bus.read_addr];
        if ((RDW_MODE != 0) && bus.we && (bus.write_addr == bus.read_addr)) begin
            rd_data_c = bus.data;
        end

        s1_valid_d = rd_acc_c;
        s1_data_d  = rd_acc_c ? rd_data_c : s1_data_q;

        if (OUT_REG != 0) begin
            out_valid_d = s1_valid_q;
            out_data_d  = s1_valid_q ? s1_data_q : out_data_q;
        end else begin
            out_valid_d = rd_acc_c;
            out_data_d  = rd_acc_c ? rd_data_c : out_data_q;
        end
    end

    // State and pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_addr_q  <= '0;
            busy_q      <= (CLEAR_ON_RESET != 0);
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            busy_q      <= busy_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Storage array, no reset so it maps onto RAM macros
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign bus.q       = out_data_q;
    assign bus.q_valid = out_valid_q;
    assign bus.busy    = (CLEAR_ON_RESET != 0) && busy_q;
endmodule

// File: tb/tb_ram_sdp_bypass.sv
// Drives five differently configured RAM instances with one shared stimulus
// and checks every output each cycle against an array/queue model.
module tb_ram_sdp_bypass;
    localparam int NI = 5;
    localparam int unsigned RDW_CFG  [NI] = '{0, 1, 0, 1, 0};
    localparam int unsigned OREG_CFG [NI] = '{0, 1, 1, 0, 0};
    localparam int unsigned CLR_CFG  [NI] = '{1, 1, 1, 1, 0};
    localparam logic [7:0]  CV = 8'h5A;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic [3:0] wa, ra;
    logic       we, re;

    logic [7:0] q_o    [NI];
    logic       qv_o   [NI];
    logic       busy_o [NI];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ram_sdp_bypass_if #(.RAM_DATA_WIDTH(8), .RAM_ADDR_WIDTH(4)) bus ();
        assign bus.data       = data;
        assign bus.write_addr = wa;
        assign bus.we         = we;
        assign bus.read_addr  = ra;
        assign bus.re         = re;
        assign q_o[g]         = bus.q;
        assign qv_o[g]        = bus.q_valid;
        assign busy_o[g]      = bus.busy;

        ram_sdp_bypass #(
            .RAM_DATA_WIDTH(8),
            .RAM_ADDR_WIDTH(4),
            .RDW_MODE(RDW_CFG[g]),
            .OUT_REG(OREG_CFG[g]),
            .CLEAR_ON_RESET(CLR_CFG[g]),
            .CLEAR_VALUE(CV)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int         inst;
        int         due;
        logic [7:0] val;
        bit         known;
    } pend_t;

    pend_t      pend [$];
    logic [7:0] m_mem   [NI][16];
    bit         m_known [NI][16];
    int         m_left  [NI];
    int         m_ptr   [NI];
    logic [7:0] e_q     [NI];
    bit         e_qk    [NI];
    bit         e_qv    [NI];
    bit         e_busy  [NI];
    bit         model_on = 1'b0;
    int         cyc = 0;

    initial begin
        for (int i = 0; i < NI; i++) begin
            for (int a = 0; a < 16; a++) m_known[i][a] = 1'b0;
        end
    end

    always @(posedge clk) begin
        logic [7:0] v;
        bit         k;
        cyc++;
        for (int i = 0; i < NI; i++) e_qv[i] = 1'b0;
        if (rst) begin
            pend.delete();
            model_on = 1'b1;
            for (int i = 0; i < NI; i++) begin
                e_q[i]    = 8'h00;
                e_qk[i]   = 1'b1;
                m_left[i] = (CLR_CFG[i] != 0) ? 16 : 0;
                m_ptr[i]  = 0;
                e_busy[i] = (CLR_CFG[i] != 0);
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (m_left[i] > 0) begin
                    m_mem[i][m_ptr[i]]   = CV;
                    m_known[i][m_ptr[i]] = 1'b1;
                    m_ptr[i]++;
                    m_left[i]--;
                end else begin
                    if (re) begin
                        v = m_mem[i][ra];
                        k = m_known[i][ra];
                        if ((RDW_CFG[i] != 0) && we && (wa == ra)) begin
                            v = data;
                            k = 1'b1;
                        end
                        pend.push_back('{i, cyc + int'(OREG_CFG[i]), v, k});
                    end
                    if (we) begin
                        m_mem[i][wa]   = data;
                        m_known[i][wa] = 1'b1;
                    end
                end
                e_busy[i] = (m_left[i] > 0);
            end
            for (int n = pend.size() - 1; n >= 0; n--) begin
                if (pend[n].due == cyc) begin
                    e_qv[pend[n].inst] = 1'b1;
                    e_q[pend[n].inst]  = pend[n].val;
                    e_qk[pend[n].inst] = pend[n].known;
                    pend.delete(n);
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (model_on) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("i%0d busy c%0d", i, cyc), 32'(busy_o[i]), 32'(e_busy[i]));
                chk($sformatf("i%0d q_valid c%0d", i, cyc), 32'(qv_o[i]), 32'(e_qv[i]));
                if (e_qk[i]) chk($sformatf("i%0d q c%0d", i, cyc), 32'(q_o[i]), 32'(e_q[i]));
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy_o[0]) break;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        rst = 1'b0; we = 1'b0; re = 1'b0; data = '0; wa = '0; ra = '0;

        // reset two cycles, with requests held during the sweep
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst q i%0d", i), 32'(q_o[i]), 32'h0);
            chk($sformatf("rst qv i%0d", i), 32'(qv_o[i]), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0; we = 1'b1; re = 1'b1; data = 8'hFF; wa = 4'd2; ra = 4'd2;
        count_busy(n);
        we = 1'b0; re = 1'b0;
        chk("clear busy cycles", 32'(n), 32'd16);
        chk("no-clear busy", 32'(busy_o[4]), 32'h0);

        // every word holds the clear value, one-cycle latency, full rate
        for (int a = 0; a < 16; a++) begin
            re = 1'b1; ra = 4'(a);
            @(negedge clk);
            chk($sformatf("clear rd qv a%0d", a), 32'(qv_o[0]), 32'h1);
            chk($sformatf("clear rd q a%0d", a), 32'(q_o[0]), 32'(CV));
        end
        re = 1'b0;

        // write then read next cycle, both output latencies
        we = 1'b1; wa = 4'd3; data = 8'hC3;
        @(negedge clk); we = 1'b0; re = 1'b1; ra = 4'd3;
        @(negedge clk); re = 1'b0;
        chk("lat0 qv", 32'(qv_o[0]), 32'h1);
        chk("lat0 q", 32'(q_o[0]), 32'hC3);
        chk("lat1 qv early", 32'(qv_o[1]), 32'h0);
        @(negedge clk);
        chk("lat1 qv", 32'(qv_o[1]), 32'h1);
        chk("lat1 q", 32'(q_o[1]), 32'hC3);
        chk("lat0 qv single", 32'(qv_o[0]), 32'h0);

        // read-during-write to addr 7, then a plain follow-up read
        we = 1'b1; wa = 4'd7; data = 8'h11;
        @(negedge clk); data = 8'h22; re = 1'b1; ra = 4'd7;
        @(negedge clk); we = 1'b0;
        chk("rdw0 q", 32'(q_o[0]), 32'h11);
        chk("rdw1 q", 32'(q_o[3]), 32'h22);
        @(negedge clk); re = 1'b0;
        chk("rdw0 next q", 32'(q_o[0]), 32'h22);
        chk("rdw1 next q", 32'(q_o[3]), 32'h22);
        chk("rdw1 oreg q", 32'(q_o[1]), 32'h22);
        chk("rdw0 oreg q", 32'(q_o[2]), 32'h11);
        @(negedge clk);
        chk("rdw1 oreg next q", 32'(q_o[1]), 32'h22);
        chk("rdw0 oreg next q", 32'(q_o[2]), 32'h22);

        // back-to-back reads of addr*3
        for (int a = 0; a < 16; a++) begin
            we = 1'b1; wa = 4'(a); data = 8'(a * 3);
            @(negedge clk);
        end
        we = 1'b0;
        for (int a = 0; a < 16; a++) begin
            re = 1'b1; ra = 4'(a);
            @(negedge clk);
            chk($sformatf("b2b qv a%0d", a), 32'(qv_o[0]), 32'h1);
            chk($sformatf("b2b q a%0d", a), 32'(q_o[0]), 32'(a * 3));
        end
        re = 1'b0;

        // reset with a read in flight and a read coincident with reset
        re = 1'b1; ra = 4'd5;
        @(negedge clk); rst = 1'b1; ra = 4'd6;
        @(negedge clk);
        chk("flush qv oreg", 32'(qv_o[1]), 32'h0);
        chk("flush q oreg", 32'(q_o[1]), 32'h0);
        rst = 1'b0; re = 1'b0;
        // restart the sweep once address 9 is due
        repeat (9) @(negedge clk);
        rst = 1'b1; re = 1'b1; ra = 4'd4;
        @(negedge clk);
        rst = 1'b0; re = 1'b0;
        chk("rst+re no qv", 32'(qv_o[4]), 32'h0);
        count_busy(n);
        chk("mid-clear busy cycles", 32'(n), 32'd16);

        // random traffic with occasional resets
        for (int c = 0; c < 500; c++) begin
            rst  = ($urandom_range(0, 79) == 0);
            we   = 1'($urandom);
            re   = 1'($urandom);
            wa   = 4'($urandom_range(0, 15));
            ra   = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            data = 8'($urandom);
            @(negedge clk);
        end
        rst = 1'b0; we = 1'b0; re = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ram_sdp_bypass.md
RAM_SDP_BYPASS -- requirements
Module: ram_sdp_bypass

Interface
REQ-001 SHALL have parameter RAM_DATA_WIDTH, default 15, word width in bits.
REQ-002 SHALL have parameter RAM_ADDR_WIDTH, default 16, address bits; depth = 2**RAM_ADDR_WIDTH.
REQ-003 SHALL have parameter RDW_MODE, default 0: read-during-write to the same address returns 0 = old data, 1 = new data.
REQ-004 SHALL have parameter OUT_REG, default 0: 1 adds one output register stage.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1: 1 enables the post-reset memory clear sweep.
REQ-006 SHALL have parameter CLEAR_VALUE, default 0, RAM_DATA_WIDTH-bit word written by the clear sweep.
REQ-007 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-008 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port data  input  RAM_DATA_WIDTH  write data.
REQ-010 SHALL have port write_addr  input  RAM_ADDR_WIDTH  write address.
REQ-011 SHALL have port we  input  1  write enable.
REQ-012 SHALL have port read_addr  input  RAM_ADDR_WIDTH  read address.
REQ-013 SHALL have port re  input  1  read enable.
REQ-014 SHALL have port q  output  RAM_DATA_WIDTH  read data.
REQ-015 SHALL have port q_valid  output  1  high for exactly one cycle when q carries the result of an accepted read.
REQ-016 SHALL have port busy  output  1  high while clear sweep is pending or running; we/re ignored.

Function
REQ-017 SHALL implement a control FSM with states CLEAR and READY.
REQ-018 SHALL, with rst high, enter CLEAR (CLEAR_ON_RESET=1) or READY (CLEAR_ON_RESET=0) and zero the clear address counter.
REQ-019 SHALL, in CLEAR, write CLEAR_VALUE to counter address each cycle, incrementing 0..2**RAM_ADDR_WIDTH-1, then move to READY after the last address write.
REQ-020 SHALL, with CLEAR_ON_RESET=1, hold busy high during rst and for exactly 2**RAM_ADDR_WIDTH cycles after rst falls; busy low from the next cycle.
REQ-021 SHALL restart the sweep at address 0 if rst asserts mid-clear.
REQ-022 SHALL hold busy low at all times when CLEAR_ON_RESET=0.
REQ-023 SHALL, while busy, ignore we and re: no user write, no q_valid, q unchanged.
REQ-024 SHALL, in READY with we=1, write data to write_addr at the clock edge.
REQ-025 SHALL, in READY with re=1, accept a read of read_addr; q and q_valid update 1+OUT_REG cycles after the accepting edge.
REQ-026 SHALL accept a new read every cycle (full throughput) in both OUT_REG settings.
REQ-027 SHALL hold q at its last value when no read result is delivered; q_valid low those cycles.
REQ-028 SHALL, on re=1, we=1, read_addr==write_addr in the same cycle, return previous contents if RDW_MODE=0, or data of that cycle if RDW_MODE=1 (bypass, not memory re-read).
REQ-029 SHALL, for a read the cycle after a write to the same address, return the new data in both modes.
REQ-030 SHALL wrap no address: counter width is RAM_ADDR_WIDTH+1 or terminal-count compare; no alias writes beyond depth.

Reset
REQ-031 SHALL, on rst high, drive q=0, q_valid=0 and flush any in-flight read in the OUT_REG pipeline.
REQ-032 SHALL NOT clear memory contents on reset when CLEAR_ON_RESET=0.
REQ-033 SHALL, when rst asserts coincident with re, discard the read (no q_valid after reset).

Verification (RAM_DATA_WIDTH=8, RAM_ADDR_WIDTH=4 unless stated)
REQ-034 SHALL cover clear: CLEAR_ON_RESET=1, CLEAR_VALUE=8'h5A, rst 2 cycles then low -> busy high 16 cycles after rst falls; reads of all 16 addresses return 8'h5A, q_valid 1 cycle after each re.
REQ-035 SHALL cover write/read latency: write 8'hC3 to addr 3, re addr 3 next cycle -> q=8'hC3, q_valid pulse at +1 cycle (OUT_REG=0) and +2 cycles (OUT_REG=1).
REQ-036 SHALL cover RDW: addr 7 holds 8'h11; same-cycle we data 8'h22 and re addr 7 -> q=8'h11 (RDW_MODE=0), q=8'h22 (RDW_MODE=1); next read 8'h22 in both.
REQ-037 SHALL cover mid-clear reset: rst pulse at sweep address 9 -> sweep restarts at 0, busy high 16 further cycles after rst falls.
REQ-038 SHALL cover busy gating: we/re asserted during clear with data 8'hFF addr 2 -> no q_valid, addr 2 reads CLEAR_VALUE after clear.
REQ-039 SHALL cover back-to-back reads: re on 16 consecutive cycles, addresses 0..15 after writing addr*3 -> 16 consecutive q_valid pulses, q = 0,3,..,45 in order.
